// File: rtl/riscv_muldiv_unit_if.sv
// Request/response bundle between the EX stage and the iterative M-extension unit.
// The unit takes the slave side; the pipeline (or a bench) drives the master side.
interface riscv_muldiv_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       funct3;
  logic [XLEN-1:0]  op_a;
  logic [XLEN-1:0]  op_b;
  logic [TAG_W-1:0] rd_in;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] rd_out;
  logic             busy;

  modport master (
    output in_valid, funct3, op_a, op_b, rd_in, flush, out_ready,
    input  in_ready, out_valid, result, rd_out, busy
  );

  modport slave (
    input  in_valid, funct3, op_a, op_b, rd_in, flush, out_ready,
    output in_ready, out_valid, result, rd_out, busy
  );
endinterface

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, with a final sign fix-up.
module riscv_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  riscv_muldiv_unit_if.slave   bus
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         f3_q, f3_d;
  logic [TAG_W-1:0]   rd_q, rd_d;
  logic               neg_q, neg_d;
  logic [XLEN-1:0]    opr_q, opr_d;
  logic [2*XLEN-1:0]  acc_q, acc_d;
  logic [XLEN-1:0]    res_q, res_d;

  logic               accept;
  logic               a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]    a_mag, b_mag;
  logic [XLEN:0]      mul_sum;
  logic [2*XLEN-1:0]  mul_next, mul_full;
  logic [XLEN:0]      div_shift, div_diff;
  logic [XLEN-1:0]    div_rem, div_quo;

  // in_ready is gated by rst so every output reads zero while reset is held.
  assign bus.in_ready  = rst && (state_q == IDLE) && !bus.flush;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.result    = res_q;
  assign bus.rd_out    = rd_q;
  assign accept        = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    neg_d   = neg_q;
    opr_d   = opr_q;
    acc_d   = acc_q;
    res_d   = res_q;

    a_signed = (bus.funct3 == 3'd1) || (bus.funct3 == 3'd2) ||
               (bus.funct3 == 3'd4) || (bus.funct3 == 3'd6);
    b_signed = (bus.funct3 == 3'd1) || (bus.funct3 == 3'd4) || (bus.funct3 == 3'd6);
    a_neg    = a_signed && bus.op_a[XLEN-1];
    b_neg    = b_signed && bus.op_b[XLEN-1];
    a_mag    = a_neg ? -bus.op_a : bus.op_a;
    b_mag    = b_neg ? -bus.op_b : bus.op_b;

    // Multiply: acc holds {partial high, remaining multiplier}, shifted right each step.
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opr_q} : {(XLEN+1){1'b0}});
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    mul_full = neg_q ? -mul_next : mul_next;

    // Divide: acc holds {partial remainder, dividend bits becoming quotient bits}.
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opr_q};
    div_rem   = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
    div_quo   = {acc_q[XLEN-2:0], ~div_diff[XLEN]};

    case (state_q)
      IDLE: begin
        if (accept) begin
          f3_d  = bus.funct3;
          rd_d  = bus.rd_in;
          cnt_d = '0;
          neg_d = (bus.funct3 == 3'd6) ? a_neg : (a_neg ^ b_neg);
          if (bus.funct3[2] && (bus.op_b == '0)) begin
            res_d   = bus.funct3[1] ? bus.op_a : {XLEN{1'b1}};
            state_d = DONE;
          end else if (b_signed && bus.funct3[2] && (bus.op_a == MOST_NEG) &&
                       (bus.op_b == {XLEN{1'b1}})) begin
            res_d   = bus.funct3[1] ? {XLEN{1'b0}} : MOST_NEG;
            state_d = DONE;
          end else if (bus.funct3[2]) begin
            acc_d   = {{XLEN{1'b0}}, a_mag};
            opr_d   = b_mag;
            state_d = DIV;
          end else begin
            acc_d   = {{XLEN{1'b0}}, b_mag};
            opr_d   = a_mag;
            state_d = MUL;
          end
        end
      end
      MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(XLEN-1)) begin
          cnt_d   = '0;
          res_d   = (f3_q == 3'd0) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
          state_d = DONE;
        end
      end
      DIV: begin
        acc_d = {div_rem, div_quo};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(XLEN-1)) begin
          cnt_d   = '0;
          res_d   = f3_q[1] ? (neg_q ? -div_rem : div_rem) : (neg_q ? -div_quo : div_quo);
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A redirect kills whatever is in flight, including an unconsumed result.
    if (bus.flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      neg_q   <= 1'b0;
      opr_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      neg_q   <= neg_d;
      opr_q   <= opr_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Bench for riscv_muldiv_unit (XLEN=32): directed and random operations compared
// against a plain-arithmetic RV32M model, plus backpressure, flush and reset.
module tb_riscv_muldiv_unit;
  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests  = 0;
  int   failed = 0;

  riscv_muldiv_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  riscv_muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // RV32M semantics computed with ordinary 32/64-bit arithmetic.
  function automatic logic [31:0] refModel(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'($signed(a) / $signed(b));
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return 32'($signed(a) % $signed(b));
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int refLatency(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    if (f3[2] && b == 0) return 0;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return XLEN;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one request across a single rising edge, then scrambles the inputs.
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd, input string tag);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.funct3   = f3;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.rd_in    = rd;
    #1 checkOutput({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.funct3   = 3'($urandom);
    bus.op_a     = $urandom;
    bus.op_b     = $urandom;
    bus.rd_in    = 5'($urandom);
  endtask

  task automatic runOp(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input string tag, input bit retire);
    int n;
    bit busyOk;
    n = 0;
    busyOk = 1'b1;
    applyStimulus(f3, a, b, rd, tag);
    while (bus.out_valid !== 1'b1 && n < 100) begin
      if (bus.busy !== 1'b1) busyOk = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    if (bus.busy !== 1'b1) busyOk = 1'b0;
    checkOutput({tag, " latency"}, 64'(n), 64'(refLatency(f3, a, b)));
    checkOutput({tag, " busy"}, 64'(busyOk), 64'd1);
    checkOutput({tag, " result"}, 64'(bus.result), 64'(refModel(f3, a, b)));
    checkOutput({tag, " rd_out"}, 64'(bus.rd_out), 64'(rd));
    if (retire) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      checkOutput({tag, " retire"}, 64'({bus.out_valid, bus.busy, bus.in_ready}), 64'b001);
    end
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    int          n;
    bit          seenValid;

    bus.in_valid  = 1'b0;
    bus.funct3    = '0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.rd_in     = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    #12;
    checkOutput("reset outputs",
                64'({bus.out_valid, bus.busy, bus.in_ready, bus.result, bus.rd_out}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1 checkOutput("post-reset idle", 64'({bus.out_valid, bus.busy, bus.in_ready}), 64'b001);

    runOp(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, "MUL 7xFFFFFFFD", 1'b1);
    runOp(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, "MULH", 1'b1);
    runOp(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, "MULHU", 1'b1);
    runOp(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3, "MULHSU", 1'b1);
    runOp(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, "DIV -7/2", 1'b1);
    runOp(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, "REM -7/2", 1'b1);
    runOp(3'd5, 32'd100, 32'd7, 5'd7, "DIVU 100/7", 1'b1);
    runOp(3'd7, 32'd100, 32'd7, 5'd8, "REMU 100/7", 1'b1);
    runOp(3'd5, 32'd5, 32'd0, 5'd9, "DIVU 5/0", 1'b1);
    runOp(3'd7, 32'd5, 32'd0, 5'd10, "REMU 5/0", 1'b1);
    runOp(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, "DIV ovf", 1'b1);
    runOp(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, "REM ovf", 1'b1);

    // Backpressure: a new request offered during DONE must be ignored.
    runOp(3'd5, 32'd100, 32'd7, 5'd13, "BP DIVU", 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.funct3   = 3'd0;
    bus.rd_in    = 5'd30;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 checkOutput("BP hold", 64'({bus.out_valid, bus.in_ready, bus.result, bus.rd_out}),
                     {25'd0, 1'b1, 1'b0, 32'd14, 5'd13});
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 checkOutput("BP release", 64'({bus.out_valid, bus.busy, bus.in_ready}), 64'b001);
    bus.out_ready = 1'b0;

    // Flush in the middle of a divide.
    applyStimulus(3'd4, 32'd1000, 32'd3, 5'd14, "FL DIV");
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 checkOutput("flush kills DIV", 64'({bus.out_valid, bus.busy}), 64'b00);
    @(negedge clk);
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    seenValid = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 if (bus.out_valid === 1'b1) seenValid = 1'b1;
    end
    bus.out_ready = 1'b0;
    checkOutput("flush no writeback", 64'(seenValid), 64'd0);
    checkOutput("flush idle", 64'({bus.busy, bus.in_ready}), 64'b01);

    // Flush together with a request in IDLE: nothing is accepted.
    @(negedge clk);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.funct3   = 3'd0;
    #1 checkOutput("flush gates in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1 checkOutput("flush no accept", 64'({bus.out_valid, bus.busy}), 64'b00);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;

    // Random operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      runOp(f3, a, b, 5'($urandom), $sformatf("RND%0d f3=%0d a=%h b=%h", i, f3, a, b), 1'b1);
    end

    // Asynchronous reset in the middle of a multiply.
    applyStimulus(3'd0, 32'd123, 32'd456, 5'd9, "RST MUL");
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 checkOutput("async reset outputs",
                   64'({bus.out_valid, bus.busy, bus.in_ready, bus.result, bus.rd_out}), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 checkOutput("reset release idle", 64'({bus.out_valid, bus.busy, bus.in_ready}), 64'b001);
    n = 0;
    runOp(3'd0, 32'd123, 32'd456, 5'd9, "MUL after reset", 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
